// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch -- program-counter / instruction-fetch stage.
//
// Issues one instruction-memory request per cycle at addr_q and captures the
// returned word into the IF/ID register.
// * A stall drops the returned word so the same address is fetched again.
// * A jump redirects the PC.
// * A jump that arrives while a request is still unanswered parks its target
//   in tgt_q. The stage then waits in DRAIN until that answer has been
//   discarded.
//
// Optional build macro: PC_FETCH_CNT_EN
//   Defined:   fetch_cnt counts captured instructions and squash_cnt counts
//              discarded responses.
//   Undefined: both counters are tied to zero and no counter logic is built.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   jump_en, jump_addr       redirect request and its target
//   stall                    hold IF/ID (ignored when jump_en=1)
//   imem_req, imem_addr      instruction-memory request and address
//   imem_ack, imem_rdata     memory response strobe and data
//   if_instr, if_pc          IF/ID instruction and its address
//   if_valid                 if_instr is live
//   flush                    combinational copy of jump_en (0 in reset)
//   fetch_cnt, squash_cnt    32-bit performance counters
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter int unsigned            PC_WIDTH   = 16,
  parameter int unsigned            INST_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_en,
  input  logic [PC_WIDTH-1:0]   jump_addr,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic                  if_valid,
  output logic                  flush,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           squash_cnt
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     addr_q, addr_d;
  logic [PC_WIDTH-1:0]     tgt_q, tgt_d;
  logic [INST_WIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic                    valid_q, valid_d;

  // Both states keep a request outstanding at addr_q; reset suppresses it.
  assign imem_req  = ~rst;
  assign imem_addr = addr_q;
  assign flush     = rst ? 1'b0 : jump_en;
  assign if_instr  = instr_q;
  assign if_pc     = pc_q;
  assign if_valid  = valid_q;

  // Next-state and IF/ID update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    case (state_q)
      ST_FETCH: begin
        if (jump_en) begin
          // A jump overrides stall and kills whatever sits in IF/ID.
          valid_d = 1'b0;
          if (imem_ack) begin
            addr_d = jump_addr;
          end else begin
            // The request at addr_q is still in flight: keep presenting it
            // until answered, then redirect.
            tgt_d   = jump_addr;
            state_d = ST_DRAIN;
          end
        end else if (imem_ack) begin
          if (stall) begin
            // Drop the word; addr_q unchanged so it is fetched again.
            addr_d = addr_q;
          end else begin
            instr_d = imem_rdata;
            pc_d    = addr_q;
            valid_d = 1'b1;
            addr_d  = addr_q + PC_ONE;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DRAIN: begin
        if (jump_en) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
        if (imem_ack) begin
          // The stale response is discarded; the newest jump target wins.
          addr_d  = jump_en ? jump_addr : tgt_q;
          state_d = ST_FETCH;
        end else if (jump_en) begin
          tgt_d = jump_addr;
        end else begin
          tgt_d = tgt_q;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      addr_q  <= RESET_PC;
      tgt_q   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

`ifdef PC_FETCH_CNT_EN
  logic        fetch_inc, squash_inc;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  // Count captures and every response that is dropped (stall, jump, drain).
  always_comb begin
    fetch_inc    = (state_q == ST_FETCH) && imem_ack && !stall && !jump_en;
    squash_inc   = imem_ack && ((state_q == ST_DRAIN) || jump_en || stall);
    fetch_cnt_d  = fetch_cnt_q  + {31'd0, fetch_inc};
    squash_cnt_d = squash_cnt_q + {31'd0, squash_inc};
  end

  // Counter registers; they wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  assign fetch_cnt  = 32'd0;
  assign squash_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch -- self-checking bench for pc_fetch (default parameters).
// A behavioural reference keeps the PC, an optional pending redirect target,
// the IF/ID contents and event counts. It is updated once per clock edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        flush;
  logic [31:0] fetch_cnt;
  logic [31:0] squash_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [15:0] m_addr;
  bit          m_pending;
  logic [15:0] m_tgt;
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic        m_valid;
  int unsigned m_fetches;
  int unsigned m_squashes;

`ifdef PC_FETCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  pc_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .flush      (flush),
    .fetch_cnt  (fetch_cnt),
    .squash_cnt (squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the rules of the fetch stage to the reference for one clock edge.
  task automatic model_edge();
    if (rst) begin
      m_addr = 16'h0000; m_pending = 1'b0; m_tgt = 16'h0000;
      m_instr = 16'h0000; m_pc = 16'h0000; m_valid = 1'b0;
      m_fetches = 0; m_squashes = 0;
    end else if (m_pending) begin
      if (jump_en) m_valid = 1'b0;
      if (imem_ack) begin
        m_addr = jump_en ? jump_addr : m_tgt;
        m_pending = 1'b0;
        m_squashes++;
      end else if (jump_en) begin
        m_tgt = jump_addr;
      end
    end else if (jump_en) begin
      m_valid = 1'b0;
      if (imem_ack) begin
        m_addr = jump_addr;
        m_squashes++;
      end else begin
        m_pending = 1'b1;
        m_tgt = jump_addr;
      end
    end else if (imem_ack) begin
      if (stall) begin
        m_squashes++;
      end else begin
        m_instr = imem_rdata;
        m_pc = m_addr;
        m_valid = 1'b1;
        m_addr = m_addr + 16'd1;
        m_fetches++;
      end
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, check registers.
  task automatic step(input logic r, input logic j, input logic [15:0] ja,
                      input logic s, input logic a, input logic [15:0] rd);
    rst = r; jump_en = j; jump_addr = ja; stall = s; imem_ack = a; imem_rdata = rd;
    #1;
    check("imem_req", {31'd0, imem_req}, {31'd0, !r});
    check("flush", {31'd0, flush}, {31'd0, (!r && j)});
    if (!r) check("imem_addr", {16'd0, imem_addr}, {16'd0, m_addr});
    @(posedge clk);
    model_edge();
    #1;
    check("if_instr", {16'd0, if_instr}, {16'd0, m_instr});
    check("if_pc", {16'd0, if_pc}, {16'd0, m_pc});
    check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    check("fetch_cnt", fetch_cnt, CNT_ON ? m_fetches : 32'd0);
    check("squash_cnt", squash_cnt, CNT_ON ? m_squashes : 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] rd;
    rst = 1'b1; jump_en = 1'b0; jump_addr = 16'h0000; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    m_addr = 16'h0000; m_pending = 1'b0; m_tgt = 16'h0000;
    m_instr = 16'h0000; m_pc = 16'h0000; m_valid = 1'b0;
    m_fetches = 0; m_squashes = 0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 16'hDEAD);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", {16'd0, if_pc}, 32'd0);

    // Sequential fetch after reset release: addresses 0,1,2,3
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA000 + 16'(i));
      check("seq_pc", {16'd0, if_pc}, i);
      check("seq_valid", {31'd0, if_valid}, 32'd1);
      check("seq_addr", {16'd0, imem_addr}, i + 1);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA004);   // now at address 5

    // Stall three cycles at address 5 with ack
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBAD0 + 16'(i));
      check("stall_addr", {16'd0, imem_addr}, 32'd5);
      check("stall_pc", {16'd0, if_pc}, 32'd4);
      check("stall_instr", {16'd0, if_instr}, 32'hA004);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA005);
    check("unstall_pc", {16'd0, if_pc}, 32'd5);
    check("unstall_instr", {16'd0, if_instr}, 32'hA005);

    // Jump with ack in the same cycle
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'hBAD1);
    check("jmp_valid", {31'd0, if_valid}, 32'd0);
    check("jmp_addr", {16'd0, imem_addr}, 32'h0040);

    // Two jumps while the request at address 9 is unanswered
    step(1'b0, 1'b1, 16'h0009, 1'b0, 1'b1, 16'hBAD2);
    step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'hBAD3);
    check("drain_hold1", {16'd0, imem_addr}, 32'd9);
    step(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'hBAD4);
    check("drain_hold2", {16'd0, imem_addr}, 32'd9);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hBAD5);
    check("drain_hold3", {16'd0, imem_addr}, 32'd9);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBAD6);
    check("drain_addr", {16'd0, imem_addr}, 32'h0200);
    check("drain_drop", {31'd0, if_valid}, 32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hC200);
    check("drain_pc", {16'd0, if_pc}, 32'h0200);
    check("drain_instr", {16'd0, if_instr}, 32'hC200);

    // Jump together with stall: redirect wins
    step(1'b0, 1'b1, 16'h0030, 1'b1, 1'b1, 16'hBAD7);
    check("jstall_addr", {16'd0, imem_addr}, 32'h0030);
    check("jstall_valid", {31'd0, if_valid}, 32'd0);

    // Counter scenario: 10 captures, 2 squashes
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h5000 + 16'(i));
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBAD8);
    step(1'b0, 1'b1, 16'h0077, 1'b0, 1'b1, 16'hBAD9);
    check("cnt_fetch10", fetch_cnt, CNT_ON ? 32'd10 : 32'd0);
    check("cnt_squash2", squash_cnt, CNT_ON ? 32'd2 : 32'd0);

    // Wrap of the PC at the top of the address space
    step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'hBADA);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hEEEE);
    check("wrap_addr", {16'd0, imem_addr}, 32'd0);
    check("wrap_pc", {16'd0, if_pc}, 32'hFFFF);

    // Randomized traffic, including occasional reset in any state
    for (int i = 0; i < 3000; i++) begin
      rd = 16'($urandom);
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 5) == 0),
           16'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1),
           rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
